// File: rtl/vai_pkg.sv
// Shared CCI-P Tx payload types, defaults and c1 FSM types for the VAI Tx mux.
package vai_pkg;

    localparam int unsigned DEF_NUM_SUB_AFUS  = 8;
    localparam int unsigned LNUM_SUB_AFUS     = $clog2(DEF_NUM_SUB_AFUS);
    localparam int unsigned DEF_FIFO_DEPTH    = 32;
    localparam int unsigned DEF_ALMFULL_SLACK = 12;
    localparam int unsigned ALMFULL_THRESH    = DEF_FIFO_DEPTH - DEF_ALMFULL_SLACK;
    localparam int unsigned DEF_C2_DEPTH      = 2;

    localparam int unsigned ADDR_W  = 42;
    localparam int unsigned MDATA_W = 16;
    localparam int unsigned DATA_W  = 512;
    localparam int unsigned TID_W   = 9;
    localparam int unsigned MMIO_W  = 64;

    typedef struct packed {
        logic [3:0]         req_type;
        logic [1:0]         cl_len;
        logic [ADDR_W-1:0]  address;
        logic [MDATA_W-1:0] mdata;
    } t_ccip_c0_ReqHdr;

    typedef struct packed {
        logic [3:0]         req_type;
        logic               sop;
        logic [1:0]         cl_len;
        logic [ADDR_W-1:0]  address;
        logic [MDATA_W-1:0] mdata;
    } t_ccip_c1_ReqHdr;

    typedef struct packed {
        logic [TID_W-1:0] tid;
    } t_ccip_c2_RspHdr;

    typedef struct packed {
        t_ccip_c0_ReqHdr hdr;
        logic            valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        t_ccip_c1_ReqHdr   hdr;
        logic [DATA_W-1:0] data;
        logic              valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        t_ccip_c2_RspHdr   hdr;
        logic [MMIO_W-1:0] data;
        logic              mmioRdValid;
    } t_if_ccip_c2_Tx;

    typedef struct packed {
        t_if_ccip_c0_Tx c0;
        t_if_ccip_c1_Tx c1;
        t_if_ccip_c2_Tx c2;
    } t_if_ccip_Tx;

    // FIFO payloads for the write and MMIO-response channels
    typedef struct packed {
        t_ccip_c1_ReqHdr   hdr;
        logic [DATA_W-1:0] data;
    } t_c1_entry;

    typedef struct packed {
        t_ccip_c2_RspHdr   hdr;
        logic [MMIO_W-1:0] data;
    } t_c2_entry;

    typedef enum logic {C1_IDLE, C1_BURST} t_c1_state;
    typedef logic [1:0] t_beats_left;

endpackage

// File: rtl/vai_tx_fifo.sv
// Synchronous FIFO with occupancy output; a push into a full FIFO is dropped
// and flagged unless the same cycle pops.
module vai_tx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic [WIDTH-1:0]        din,
    input  logic                    pop,
    output logic [WIDTH-1:0]        head,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    ovf
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
    logic             full, do_push, do_pop;

    always_comb begin
        full     = (count_q == CW'(DEPTH));
        do_pop   = pop && (count_q != '0);
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + CW'(do_push);
        rd_ptr_d = rd_ptr_q + CW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy alone defines validity
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

    assign head  = mem_q[rd_ptr_q[AW-1:0]];
    assign count = count_q;
    assign ovf   = push && full && !do_pop;

endmodule

// File: rtl/vai_tx_mux.sv
// Merges per-sub-AFU CCI-P Tx streams onto the host Tx port with per-channel
// round-robin and atomic multi-CL writes. Optional counters: VAI_TX_MUX_STATS_EN.
module vai_tx_mux
    import vai_pkg::*;
#(
    parameter int unsigned NUM_SUB_AFUS  = DEF_NUM_SUB_AFUS,
    parameter int unsigned FIFO_DEPTH    = DEF_FIFO_DEPTH,
    parameter int unsigned ALMFULL_SLACK = DEF_ALMFULL_SLACK,
    parameter int unsigned C2_DEPTH      = DEF_C2_DEPTH
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  t_if_ccip_Tx             up_TxPort [NUM_SUB_AFUS],
    output logic [NUM_SUB_AFUS-1:0] up_c0AlmFull,
    output logic [NUM_SUB_AFUS-1:0] up_c1AlmFull,
    output t_if_ccip_Tx             host_TxPort,
    input  logic                    c0TxAlmFull,
    input  logic                    c1TxAlmFull,
    output logic [NUM_SUB_AFUS-1:0] overflow_err
`ifdef VAI_TX_MUX_STATS_EN
    ,
    output logic [31:0]             stat_c0_grants [NUM_SUB_AFUS],
    output logic [31:0]             stat_c1_grants [NUM_SUB_AFUS],
    output logic [31:0]             stat_hold_cycles
`endif
);

    localparam int unsigned N         = NUM_SUB_AFUS;
    localparam int unsigned LN        = $clog2(NUM_SUB_AFUS);
    localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned C2CW      = $clog2(C2_DEPTH) + 1;
    localparam int unsigned AF_THRESH = FIFO_DEPTH - ALMFULL_SLACK;

    // Returns {found, index} of the first requester at or after start
    function automatic logic [LN:0] rr_pick(input logic [N-1:0] req, input logic [LN-1:0] start);
        logic [LN:0]   res;
        logic [LN-1:0] idx;
        res = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = start + LN'(k);
            if (req[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    logic [N-1:0]     c0_req, c1_req, c2_req, c0_pop, c1_pop, c2_pop, c0_ovf, c1_ovf, c2_ovf;
    logic [CW-1:0]    c0_cnt [N];
    logic [CW-1:0]    c1_cnt [N];
    logic [C2CW-1:0]  c2_cnt [N];
    t_ccip_c0_ReqHdr  c0_head [N];
    t_c1_entry        c1_head [N];
    t_c2_entry        c2_head [N];

    for (genvar i = 0; i < N; i++) begin : g_port
        vai_tx_fifo #(.WIDTH($bits(t_ccip_c0_ReqHdr)), .DEPTH(FIFO_DEPTH)) u_c0_fifo (
            .clk(clk), .rst_n(reset_n), .push(up_TxPort[i].c0.valid), .din(up_TxPort[i].c0.hdr),
            .pop(c0_pop[i]), .head(c0_head[i]), .count(c0_cnt[i]), .ovf(c0_ovf[i]));
        vai_tx_fifo #(.WIDTH($bits(t_c1_entry)), .DEPTH(FIFO_DEPTH)) u_c1_fifo (
            .clk(clk), .rst_n(reset_n), .push(up_TxPort[i].c1.valid),
            .din({up_TxPort[i].c1.hdr, up_TxPort[i].c1.data}),
            .pop(c1_pop[i]), .head(c1_head[i]), .count(c1_cnt[i]), .ovf(c1_ovf[i]));
        vai_tx_fifo #(.WIDTH($bits(t_c2_entry)), .DEPTH(C2_DEPTH)) u_c2_fifo (
            .clk(clk), .rst_n(reset_n), .push(up_TxPort[i].c2.mmioRdValid),
            .din({up_TxPort[i].c2.hdr, up_TxPort[i].c2.data}),
            .pop(c2_pop[i]), .head(c2_head[i]), .count(c2_cnt[i]), .ovf(c2_ovf[i]));
        assign c0_req[i] = (c0_cnt[i] != '0);
        assign c1_req[i] = (c1_cnt[i] != '0);
        assign c2_req[i] = (c2_cnt[i] != '0);
    end

    logic          c0_af_q, c1_af_q;
    logic [LN-1:0] c0_rr_q, c0_rr_d, c2_rr_q, c2_rr_d, c1_rr_q, c1_rr_d, c1_lock_q, c1_lock_d;
    t_c1_state     c1_state_q, c1_state_d;
    t_beats_left   c1_beats_q, c1_beats_d;
    t_if_ccip_Tx   host_q, host_d;
    logic [N-1:0]  c0_afl_q, c0_afl_d, c1_afl_q, c1_afl_d, err_q, err_d;
    logic [LN:0]   c0_pick, c1_pick, c2_pick;
    logic [LN-1:0] c0_gnt, c1_gnt, c2_gnt;
    logic          c0_go, c1_go, c2_go;
    t_c1_entry     c1_sel;

    // Read and MMIO-response arbitration: one beat per cycle each
    always_comb begin
        c0_pick = rr_pick(c0_req, c0_rr_q);
        c0_go   = c0_pick[LN] && !c0_af_q;
        c0_gnt  = c0_pick[LN-1:0];
        c0_pop  = c0_go ? (N'(1) << c0_gnt) : '0;
        c0_rr_d = c0_go ? c0_gnt + LN'(1) : c0_rr_q;
        c2_pick = rr_pick(c2_req, c2_rr_q);
        c2_go   = c2_pick[LN];
        c2_gnt  = c2_pick[LN-1:0];
        c2_pop  = c2_go ? (N'(1) << c2_gnt) : '0;
        c2_rr_d = c2_go ? c2_gnt + LN'(1) : c2_rr_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c1_state_q <= C1_IDLE;
            c1_beats_q <= '0;
            c1_lock_q  <= '0;
            c1_rr_q    <= '0;
        end else begin
            c1_state_q <= c1_state_d;
            c1_beats_q <= c1_beats_d;
            c1_lock_q  <= c1_lock_d;
            c1_rr_q    <= c1_rr_d;
        end
    end

    // Packet boundaries: lock on a multi-CL start, advance RR only on completion
    always_comb begin
        c1_state_d = c1_state_q;
        c1_beats_d = c1_beats_q;
        c1_lock_d  = c1_lock_q;
        c1_rr_d    = c1_rr_q;
        if (c1_go) begin
            if (c1_state_q == C1_IDLE) begin
                if (c1_sel.hdr.sop && (c1_sel.hdr.cl_len != 2'd0)) begin
                    c1_state_d = C1_BURST;
                    c1_beats_d = t_beats_left'(c1_sel.hdr.cl_len);
                    c1_lock_d  = c1_gnt;
                end else begin
                    c1_rr_d = c1_gnt + LN'(1);
                end
            end else begin
                c1_beats_d = c1_beats_q - t_beats_left'(1);
                if (c1_beats_q == t_beats_left'(1)) begin
                    c1_state_d = C1_IDLE;
                    c1_rr_d    = c1_lock_q + LN'(1);
                end
            end
        end
    end

    // Mid-burst the lock holds even when the locked FIFO is empty
    always_comb begin
        c1_go   = 1'b0;
        c1_gnt  = c1_lock_q;
        c1_pick = rr_pick(c1_req, c1_rr_q);
        if (c1_state_q == C1_IDLE) begin
            if (c1_pick[LN] && !c1_af_q) begin
                c1_go  = 1'b1;
                c1_gnt = c1_pick[LN-1:0];
            end
        end else begin
            c1_go = c1_req[c1_lock_q];
        end
        c1_pop = c1_go ? (N'(1) << c1_gnt) : '0;
        c1_sel = c1_head[c1_gnt];
    end

    always_comb begin
        host_d                = '0;
        host_d.c0.hdr         = c0_head[c0_gnt];
        host_d.c0.valid       = c0_go;
        host_d.c1.hdr         = c1_sel.hdr;
        host_d.c1.data        = c1_sel.data;
        host_d.c1.valid       = c1_go;
        host_d.c2.hdr         = c2_head[c2_gnt].hdr;
        host_d.c2.data        = c2_head[c2_gnt].data;
        host_d.c2.mmioRdValid = c2_go;
        for (int i = 0; i < N; i++) begin
            c0_afl_d[i] = (c0_cnt[i] >= CW'(AF_THRESH));
            c1_afl_d[i] = (c1_cnt[i] >= CW'(AF_THRESH));
        end
        err_d = err_q | c0_ovf | c1_ovf | c2_ovf;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            host_q   <= '0;
            c0_af_q  <= 1'b0;
            c1_af_q  <= 1'b0;
            c0_rr_q  <= '0;
            c2_rr_q  <= '0;
            c0_afl_q <= '0;
            c1_afl_q <= '0;
            err_q    <= '0;
        end else begin
            host_q   <= host_d;
            c0_af_q  <= c0TxAlmFull;
            c1_af_q  <= c1TxAlmFull;
            c0_rr_q  <= c0_rr_d;
            c2_rr_q  <= c2_rr_d;
            c0_afl_q <= c0_afl_d;
            c1_afl_q <= c1_afl_d;
            err_q    <= err_d;
        end
    end

    assign host_TxPort  = host_q;
    assign up_c0AlmFull = c0_afl_q;
    assign up_c1AlmFull = c1_afl_q;
    assign overflow_err = err_q;

`ifdef VAI_TX_MUX_STATS_EN
    logic [31:0] st_c0_q [N];
    logic [31:0] st_c0_d [N];
    logic [31:0] st_c1_q [N];
    logic [31:0] st_c1_d [N];
    logic [31:0] hold_q, hold_d;

    // Hold counts cycles where a ready head waits only on host almost-full
    always_comb begin
        for (int i = 0; i < N; i++) begin
            st_c0_d[i] = st_c0_q[i] + 32'(c0_pop[i]);
            st_c1_d[i] = st_c1_q[i] + 32'(c1_pop[i]);
        end
        hold_d = hold_q + 32'(((|c0_req) && c0_af_q) ||
                              ((c1_state_q == C1_IDLE) && (|c1_req) && c1_af_q));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                st_c0_q[i] <= '0;
                st_c1_q[i] <= '0;
            end
            hold_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                st_c0_q[i] <= st_c0_d[i];
                st_c1_q[i] <= st_c1_d[i];
            end
            hold_q <= hold_d;
        end
    end

    assign stat_c0_grants   = st_c0_q;
    assign stat_c1_grants   = st_c1_q;
    assign stat_hold_cycles = hold_q;
`endif

endmodule

// File: tb/tb_vai_tx_mux.sv
// Directed self-checking bench for vai_tx_mux (default build, 8 ports).
module tb_vai_tx_mux;
    import vai_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    t_if_ccip_Tx up_tx [8];
    logic [7:0]  up_c0af, up_c1af, ovf;
    t_if_ccip_Tx host;
    logic        c0_af, c1_af;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    vai_tx_mux #(.NUM_SUB_AFUS(8), .FIFO_DEPTH(32), .ALMFULL_SLACK(12), .C2_DEPTH(2)) dut (
        .clk(clk), .reset_n(reset_n), .up_TxPort(up_tx), .up_c0AlmFull(up_c0af),
        .up_c1AlmFull(up_c1af), .host_TxPort(host), .c0TxAlmFull(c0_af),
        .c1TxAlmFull(c1_af), .overflow_err(ovf));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        for (int i = 0; i < 8; i++) up_tx[i] = '0;
    endtask

    task automatic c1_push(input int p, input logic sop, input logic [1:0] len, input logic [15:0] md);
        up_tx[p].c1.valid         = 1'b1;
        up_tx[p].c1.hdr.req_type  = 4'h2;
        up_tx[p].c1.hdr.sop       = sop;
        up_tx[p].c1.hdr.cl_len    = len;
        up_tx[p].c1.hdr.address   = 42'(md) << 2;
        up_tx[p].c1.hdr.mdata     = md;
        up_tx[p].c1.data          = 512'(md) ^ 512'h5A5A;
    endtask

    task automatic c0_push(input int p, input logic [15:0] md);
        up_tx[p].c0.valid        = 1'b1;
        up_tx[p].c0.hdr.req_type = 4'h1;
        up_tx[p].c0.hdr.address  = 42'(md) + 42'h1000;
        up_tx[p].c0.hdr.mdata    = md;
    endtask

    task automatic check_c1(input string tag, input logic v, input logic [15:0] md);
        chk({tag, "_v"}, 64'(host.c1.valid), 64'(v));
        if (v) chk({tag, "_md"}, 64'(host.c1.hdr.mdata), 64'(md));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clr();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        c0_af   = 1'b0;
        c1_af   = 1'b0;
        clr();
        repeat (2) @(negedge clk);
        chk("rst_valids", 64'({host.c0.valid, host.c1.valid, host.c2.mmioRdValid}), 64'(0));
        chk("rst_c0af", 64'(up_c0af), 64'(0));
        chk("rst_c1af", 64'(up_c1af), 64'(0));
        chk("rst_ovf", 64'(ovf), 64'(0));
        reset_n = 1'b1;
        @(negedge clk);

        // Single c0 read: two-cycle latency, header unchanged
        up_tx[3].c0.valid        = 1'b1;
        up_tx[3].c0.hdr.req_type = 4'h1;
        up_tx[3].c0.hdr.address  = 42'h1234;
        up_tx[3].c0.hdr.mdata    = 16'h3005;
        @(negedge clk);
        clr();
        chk("t1_early", 64'(host.c0.valid), 64'(0));
        @(negedge clk);
        chk("t1_v", 64'(host.c0.valid), 64'(1));
        chk("t1_addr", 64'(host.c0.hdr.address), 64'h1234);
        chk("t1_md", 64'(host.c0.hdr.mdata), 64'h3005);
        chk("t1_type", 64'(host.c0.hdr.req_type), 64'h1);
        chk("t1_others", 64'({host.c1.valid, host.c2.mmioRdValid}), 64'(0));
        @(negedge clk);
        chk("t1_after", 64'(host.c0.valid), 64'(0));
        do_reset();

        // All eight ports at once: ports 0..7 in order, then RR wraps to 0
        for (int i = 0; i < 8; i++) c0_push(i, 16'(16'h100 + i));
        @(negedge clk);
        clr();
        chk("t2_early", 64'(host.c0.valid), 64'(0));
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("t2_v%0d", k), 64'(host.c0.valid), 64'(1));
            chk($sformatf("t2_md%0d", k), 64'(host.c0.hdr.mdata), 64'(16'h100 + k));
        end
        c0_push(2, 16'h202);
        c0_push(0, 16'h200);
        @(negedge clk);
        clr();
        @(negedge clk);
        chk("t2_wrap0", 64'(host.c0.hdr.mdata), 64'h200);
        @(negedge clk);
        chk("t2_wrap2", 64'(host.c0.hdr.mdata), 64'h202);

        // 4-CL burst on port 2 with a source gap; port 5 singles must wait
        clr(); c1_push(2, 1'b1, 2'd3, 16'h20); c1_push(5, 1'b1, 2'd0, 16'h50);
        @(negedge clk);
        clr(); c1_push(2, 1'b0, 2'd3, 16'h21); c1_push(5, 1'b1, 2'd0, 16'h51);
        @(negedge clk);
        check_c1("t3_b0", 1'b1, 16'h20);
        chk("t3_b0_addr", 64'(host.c1.hdr.address), 64'h80);
        chk("t3_b0_data", host.c1.data[63:0], 64'h5A7A);
        clr();
        @(negedge clk);
        check_c1("t3_b1", 1'b1, 16'h21);
        clr(); c1_push(2, 1'b0, 2'd3, 16'h22);
        @(negedge clk);
        check_c1("t3_gap", 1'b0, 16'h0);
        clr(); c1_push(2, 1'b0, 2'd3, 16'h23);
        @(negedge clk);
        check_c1("t3_b2", 1'b1, 16'h22);
        clr();
        @(negedge clk);
        check_c1("t3_b3", 1'b1, 16'h23);
        @(negedge clk);
        check_c1("t3_w0", 1'b1, 16'h50);
        @(negedge clk);
        check_c1("t3_w1", 1'b1, 16'h51);
        @(negedge clk);
        check_c1("t3_idle", 1'b0, 16'h0);

        // Host c1 almost-full: port 4 fills, almost-full then overflow
        c1_af = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 33; k++) begin
            clr();
            c1_push(4, 1'b1, 2'd0, 16'(k));
            @(negedge clk);
            chk($sformatf("t4_noout%0d", k), 64'(host.c1.valid), 64'(0));
            if (k == 20) chk("t4_af_lo", 64'(up_c1af), 64'h00);
            if (k == 21) chk("t4_af_hi", 64'(up_c1af), 64'h10);
            if (k == 32) chk("t4_ovf_lo", 64'(ovf), 64'h00);
            if (k == 33) chk("t4_ovf_hi", 64'(ovf), 64'h10);
        end
        clr();

        // Reset in the middle of a port-2 burst while port 4 is still full
        c1_af = 1'b0;
        c1_push(2, 1'b1, 2'd3, 16'h30);
        @(negedge clk);
        clr(); c1_push(2, 1'b0, 2'd3, 16'h31);
        @(negedge clk);
        check_c1("t6_b0", 1'b1, 16'h30);
        clr(); c1_push(2, 1'b0, 2'd3, 16'h32);
        @(negedge clk);
        check_c1("t6_b1", 1'b1, 16'h31);
        chk("t6_pre_ovf", 64'(ovf), 64'h10);
        chk("t6_pre_af", 64'(up_c1af), 64'h10);
        reset_n = 1'b0;
        clr();
        #1;
        chk("t6_rst_valid", 64'({host.c0.valid, host.c1.valid, host.c2.mmioRdValid}), 64'(0));
        chk("t6_rst_af", 64'({up_c0af, up_c1af}), 64'(0));
        chk("t6_rst_ovf", 64'(ovf), 64'(0));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("t6_stale%0d", k), 64'({host.c0.valid, host.c1.valid, host.c2.mmioRdValid}), 64'(0));
        end
        chk("t6_post_af", 64'(up_c1af), 64'(0));
        c1_push(5, 1'b1, 2'd0, 16'h77);
        @(negedge clk);
        clr();
        check_c1("t6_new_early", 1'b0, 16'h0);
        @(negedge clk);
        check_c1("t6_new", 1'b1, 16'h77);

        // Two MMIO responses under saturated c0/c1 traffic
        for (int cyc = 0; cyc < 4; cyc++) begin
            clr();
            for (int i = 0; i < 8; i++) begin
                c0_push(i, 16'(16'h400 + cyc * 8 + i));
                c1_push(i, 1'b1, 2'd0, 16'(16'h500 + cyc * 8 + i));
            end
            if (cyc == 0) begin
                up_tx[1].c2.mmioRdValid = 1'b1;
                up_tx[1].c2.hdr.tid     = 9'd1;
                up_tx[1].c2.data        = 64'hD1;
                up_tx[6].c2.mmioRdValid = 1'b1;
                up_tx[6].c2.hdr.tid     = 9'd6;
                up_tx[6].c2.data        = 64'hD6;
            end
            @(negedge clk);
            if (cyc == 0) chk("t5_c2_early", 64'(host.c2.mmioRdValid), 64'(0));
            if (cyc == 1) begin
                chk("t5_c2a_v", 64'(host.c2.mmioRdValid), 64'(1));
                chk("t5_c2a_tid", 64'(host.c2.hdr.tid), 64'(1));
                chk("t5_c2a_data", host.c2.data, 64'hD1);
            end
            if (cyc == 2) begin
                chk("t5_c2b_v", 64'(host.c2.mmioRdValid), 64'(1));
                chk("t5_c2b_tid", 64'(host.c2.hdr.tid), 64'(6));
                chk("t5_c2b_data", host.c2.data, 64'hD6);
            end
            if (cyc == 3) chk("t5_c2_done", 64'(host.c2.mmioRdValid), 64'(0));
            if (cyc >= 1) chk($sformatf("t5_c0c1_%0d", cyc), 64'({host.c0.valid, host.c1.valid}), 64'h3);
        end
        clr();
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
